seven_segment_scan_controller: RTL and testbench

//   Sequential front end for the four-digit seven-segment display. Accepts a binary value over a

---
 rtl/seven_seg_pkg.sv | 20 ++
 rtl/bcd_to_seven_segment_decoder.sv | 24 ++
 rtl/seven_segment_scan_controller.sv | 138 +++++++++++++
 tb/tb_seven_segment_scan_controller.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/seven_seg_pkg.sv
// Shared types and constants for the four-digit seven-segment scan controller.
package seven_seg_pkg;

    localparam int NUM_DIGITS = 4;
    localparam int BCD_W      = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LATCH = 2'd2
    } state_e;

    localparam logic [NUM_DIGITS-1:0] ANODE_TABLE [NUM_DIGITS] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};

    // Double-dabble correction: a nibble of 5 or more would overflow past 9 after doubling.
    function automatic logic [BCD_W-1:0] dd_adjust(input logic [BCD_W-1:0] nib);
        return (nib >= 4'd5) ? nib + 4'd3 : nib;
    endfunction

endpackage

// File: rtl/bcd_to_seven_segment_decoder.sv
// BCD digit to active-high segments, bit order {g,f,e,d,c,b,a}; non-decimal codes are dark.
module bcd_to_seven_segment_decoder (
    input  logic [3:0] bcd,
    output logic [6:0] segment
);

    // Segment lookup for the decimal digits.
    always_comb begin
        case (bcd)
            4'd0:    segment = 7'h3F;
            4'd1:    segment = 7'h06;
            4'd2:    segment = 7'h5B;
            4'd3:    segment = 7'h4F;
            4'd4:    segment = 7'h66;
            4'd5:    segment = 7'h6D;
            4'd6:    segment = 7'h7D;
            4'd7:    segment = 7'h07;
            4'd8:    segment = 7'h7F;
            4'd9:    segment = 7'h6F;
            default: segment = 7'h00;
        endcase
    end

endmodule

// File: rtl/seven_segment_scan_controller.sv
// Binary-to-BCD conversion by iterative double-dabble, then time-multiplexed display of four
// digits through a single shared segment decoder.
module seven_segment_scan_controller
    import seven_seg_pkg::*;
#(
    parameter int WIDTH            = 10,
    parameter int SCAN_DIV         = 50000,
    parameter bit ANODE_ACTIVE_LOW = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             value_valid,
    input  logic [WIDTH-1:0] value,
    output logic             value_ready,
    output logic             busy,
    input  logic             blank_zeros,
    output logic [6:0]       segment,
    output logic [3:0]       anode
);

    localparam int CNT_W  = $clog2(WIDTH + 1);
    localparam int SCAN_W = $clog2(SCAN_DIV);

    state_e                             state_q, state_d;
    logic [WIDTH-1:0]                   shift_q, shift_d;
    logic [NUM_DIGITS*BCD_W-1:0]        bcd_q, bcd_d;
    logic [CNT_W-1:0]                   bitcnt_q, bitcnt_d;
    logic [NUM_DIGITS-1:0][BCD_W-1:0]   digits_q, digits_d;
    logic [SCAN_W-1:0]                  scan_cnt_q, scan_cnt_d;
    logic [1:0]                         scan_idx_q, scan_idx_d;

    logic [NUM_DIGITS*BCD_W-1:0]        adj_s;
    logic [NUM_DIGITS*BCD_W+WIDTH-1:0]  dd_s;
    logic [NUM_DIGITS-1:0]              lead_zero_s;
    logic                               blank_s;
    logic [NUM_DIGITS-1:0]              onehot_s;

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            bcd_q      <= '0;
            bitcnt_q   <= '0;
            digits_q   <= '0;
            scan_cnt_q <= '0;
            scan_idx_q <= 2'd0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bcd_q      <= bcd_d;
            bitcnt_q   <= bitcnt_d;
            digits_q   <= digits_d;
            scan_cnt_q <= scan_cnt_d;
            scan_idx_q <= scan_idx_d;
        end
    end

    // Conversion FSM: load on handshake, shift WIDTH times, then publish the digits.
    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        bcd_d    = bcd_q;
        bitcnt_d = bitcnt_q;
        digits_d = digits_q;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            adj_s[k*BCD_W +: BCD_W] = dd_adjust(bcd_q[k*BCD_W +: BCD_W]);
        end
        dd_s = {adj_s, shift_q} << 1;
        case (state_q)
            IDLE: begin
                if (value_valid) begin
                    shift_d  = value;
                    bcd_d    = '0;
                    bitcnt_d = '0;
                    state_d  = SHIFT;
                end else begin
                    state_d  = IDLE;
                end
            end
            SHIFT: begin
                {bcd_d, shift_d} = dd_s;
                bitcnt_d         = bitcnt_q + CNT_W'(1);
                if (bitcnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = LATCH;
                end else begin
                    state_d = SHIFT;
                end
            end
            LATCH: begin
                digits_d = bcd_q;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Free-running scan timer, independent of the conversion.
    always_comb begin
        if (scan_cnt_q == SCAN_W'(SCAN_DIV - 1)) begin
            scan_cnt_d = '0;
            scan_idx_d = scan_idx_q + 2'd1;
        end else begin
            scan_cnt_d = scan_cnt_q + SCAN_W'(1);
            scan_idx_d = scan_idx_q;
        end
    end

    // Leading-zero blanking and anode drive; the units digit always lights.
    always_comb begin
        lead_zero_s[NUM_DIGITS-1] = (digits_q[NUM_DIGITS-1] == 4'd0);
        for (int k = NUM_DIGITS - 2; k >= 0; k--) begin
            lead_zero_s[k] = lead_zero_s[k+1] & (digits_q[k] == 4'd0);
        end
        blank_s = blank_zeros & lead_zero_s[scan_idx_q] & (scan_idx_q != 2'd0);
        if (blank_s) begin
            onehot_s = 4'b0000;
        end else begin
            onehot_s = ANODE_TABLE[scan_idx_q];
        end
        if (ANODE_ACTIVE_LOW) begin
            anode = ~onehot_s;
        end else begin
            anode = onehot_s;
        end
    end

    assign value_ready = (state_q == IDLE);
    assign busy        = (state_q == SHIFT) || (state_q == LATCH);

    bcd_to_seven_segment_decoder u_dec (
        .bcd     (digits_q[scan_idx_q]),
        .segment (segment)
    );

endmodule

// File: tb/tb_seven_segment_scan_controller.sv
// Scoreboard bench: converted values are queued on transfer and checked against the scanned display.
module tb_seven_segment_scan_controller;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        blank_zeros = 1'b0;

    logic        v10_valid = 1'b0;
    logic [9:0]  v10 = 10'd0;
    logic        r10, b10;
    logic [6:0]  seg10;
    logic [3:0]  an10;

    logic        v13_valid = 1'b0;
    logic [12:0] v13 = 13'd0;
    logic        r13, b13;
    logic [6:0]  seg13;
    logic [3:0]  an13;

    int checks = 0;
    int errors = 0;
    int exp_q[$];

    always #5 clk = ~clk;

    seven_segment_scan_controller #(.WIDTH(10), .SCAN_DIV(4), .ANODE_ACTIVE_LOW(1'b1)) dut10 (
        .clk(clk), .rst_n(rst_n), .value_valid(v10_valid), .value(v10), .value_ready(r10),
        .busy(b10), .blank_zeros(blank_zeros), .segment(seg10), .anode(an10)
    );

    seven_segment_scan_controller #(.WIDTH(13), .SCAN_DIV(4), .ANODE_ACTIVE_LOW(1'b1)) dut13 (
        .clk(clk), .rst_n(rst_n), .value_valid(v13_valid), .value(v13), .value_ready(r13),
        .busy(b13), .blank_zeros(blank_zeros), .segment(seg13), .anode(an13)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0: return 7'h3F;  1: return 7'h06;  2: return 7'h5B;  3: return 7'h4F;
            4: return 7'h66;  5: return 7'h6D;  6: return 7'h7D;  7: return 7'h07;
            8: return 7'h7F;  9: return 7'h6F;
            default: return 7'h00;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input bit sel, input int v);
        int n = 0;
        while (!(sel ? r13 : r10) && n < 100) begin
            tick();
            n++;
        end
        check("ready_wait", 32'(n < 100), 32'd1);
        if (sel) begin v13_valid = 1'b1; v13 = 13'(v); end
        else     begin v10_valid = 1'b1; v10 = 10'(v); end
        tick();
        v13_valid = 1'b0;
        v10_valid = 1'b0;
        exp_q.push_back(v);
    endtask

    task automatic finish_conv(input bit sel, input int exp_busy);
        int n = 0;
        while ((sel ? b13 : b10) && n < 100) begin
            n++;
            tick();
        end
        check("busy_cycles", n, exp_busy);
        check("ready_back", 32'(sel ? r13 : r10), 32'd1);
    endtask

    task automatic check_scan(input bit sel, input int v, input bit blank, input int cycles, input bit full);
        int d[4];
        logic [3:0] mask;
        logic [3:0] seen;
        logic [3:0] oh;
        logic [6:0] sg;
        bit zero_above;
        for (int k = 0; k < 4; k++) d[k] = (v / (10 ** k)) % 10;
        mask = 4'b0001;
        zero_above = 1'b1;
        for (int k = 3; k >= 1; k--) begin
            zero_above = zero_above && (d[k] == 0);
            if (!(blank && zero_above)) mask[k] = 1'b1;
        end
        seen = 4'b0000;
        for (int i = 0; i < cycles; i++) begin
            oh = ~(sel ? an13 : an10);
            sg = sel ? seg13 : seg10;
            if (oh != 4'b0000) begin
                check("anode_onehot", 32'($onehot(oh)), 32'd1);
                for (int k = 0; k < 4; k++) begin
                    if (oh[k]) begin
                        seen[k] = 1'b1;
                        check($sformatf("seg_slot%0d", k), 32'(sg), 32'(seg_of(d[k])));
                    end
                end
            end
            tick();
        end
        if (full) check("anode_mask", 32'(seen), 32'(mask));
    endtask

    initial begin
        int v;
        #22;
        check("rst_anode", 32'(an10), 32'hE);
        check("rst_seg", 32'(seg10), 32'(seg_of(0)));
        check("rst_ready", 32'(r10), 32'd1);
        check("rst_busy", 32'(b10), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k < 16; k++) begin
            tick();
            check("rotate", 32'(an10), 32'(4'(~(4'b0001 << ((k / 4) % 4)))));
            check("rotate_seg", 32'(seg10), 32'(seg_of(0)));
        end

        load(1'b0, 1023);
        finish_conv(1'b0, 11);
        v = exp_q.pop_front();
        check_scan(1'b0, v, 1'b0, 16, 1'b1);

        blank_zeros = 1'b1;
        load(1'b0, 7);
        finish_conv(1'b0, 11);
        v = exp_q.pop_front();
        check_scan(1'b0, v, 1'b1, 16, 1'b1);
        blank_zeros = 1'b0;
        check_scan(1'b0, v, 1'b0, 16, 1'b1);

        // 555 held on the bus while 42 converts; it must wait for value_ready.
        v10_valid = 1'b1;
        v10 = 10'd42;
        tick();
        exp_q.push_back(42);
        v10 = 10'd555;
        finish_conv(1'b0, 11);
        exp_q.push_back(555);
        v = exp_q.pop_front();
        tick();
        v10_valid = 1'b0;
        check("busy_555", 32'(b10), 32'd1);
        check_scan(1'b0, v, 1'b0, 10, 1'b0);
        finish_conv(1'b0, 1);
        v = exp_q.pop_front();
        check_scan(1'b0, v, 1'b0, 16, 1'b1);

        load(1'b0, 999);
        finish_conv(1'b0, 11);
        v = exp_q.pop_front();
        check_scan(1'b0, v, 1'b0, 16, 1'b1);
        load(1'b0, 321);
        repeat (4) tick();
        rst_n = 1'b0;
        #1;
        check("abort_anode", 32'(an10), 32'h E);
        check("abort_seg", 32'(seg10), 32'(seg_of(0)));
        check("abort_ready", 32'(r10), 32'd1);
        check("abort_busy", 32'(b10), 32'd0);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        load(1'b0, 321);
        finish_conv(1'b0, 11);
        v = exp_q.pop_front();
        check_scan(1'b0, v, 1'b0, 16, 1'b1);

        load(1'b1, 8191);
        finish_conv(1'b1, 14);
        v = exp_q.pop_front();
        check_scan(1'b1, v, 1'b0, 16, 1'b1);
        load(1'b1, 0);
        finish_conv(1'b1, 14);
        v = exp_q.pop_front();
        check_scan(1'b1, v, 1'b0, 16, 1'b1);
        check("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
